// File: rtl/sub_divider_ctrl.sv
// ---------------------------------------------------------------------------
// sub_divider_ctrl
//   Iterative restoring divider. One quotient bit is produced per cycle by a
//   single shared WIDTH+1 bit subtractor: the partial remainder is shifted
//   left with the next dividend bit, the divisor is subtracted, and the sign
//   of the difference decides whether the difference is kept (quotient bit 1)
//   or the shifted remainder is restored (quotient bit 0).
//
//   Optional feature macro: DIV_SIGNED_EN
//     When defined, an is_signed input is added. Signed operands are turned
//     into magnitudes at accept, and an extra FIX state restores the signs
//     (quotient negated if operand signs differ, remainder follows dividend).
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        request, sampled only in IDLE
//   dividend     numerator, sampled with an accepted start
//   divisor      denominator, sampled with an accepted start
//   is_signed    (DIV_SIGNED_EN only) signed operation, sampled with start
//   busy         high whenever the FSM is not IDLE
//   done         one-cycle pulse, results valid
//   quotient     registered result, held until the next result
//   remainder    registered result, held until the next result
//   div_by_zero  registered flag, set on a divide-by-zero request, cleared
//                by the next accepted start with a non-zero divisor
//   dbg_state    current FSM state (0 IDLE, 1 RUN, 2 DONE, 3 FIX)
//
// Handshake: start is a level request; it is accepted on the rising edge
// where the FSM is IDLE and start=1. Starts seen while busy are dropped.
// done pulses for one cycle once the results are in quotient/remainder.
// ---------------------------------------------------------------------------
module sub_divider_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
  input  logic             is_signed,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       dbg_state
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   dvd_q;      // remaining dividend bits, MSB first
  logic [WIDTH-1:0]   dvs_q;      // divisor magnitude
  logic [WIDTH-1:0]   rem_q;      // partial remainder
  logic [WIDTH-1:0]   quo_q;      // partial quotient
  logic [WIDTH-1:0]   quotient_q, remainder_q;
  logic               dz_q, done_q;

  logic               accept, dvs_zero;
  logic [WIDTH-1:0]   dvd_mag, dvs_mag;
  logic [WIDTH:0]     sub_a, sub_b, sub_res;
  logic               sgn;

`ifdef DIV_SIGNED_EN
  logic               fix_q;      // current operation needs the FIX state
  logic               neg_quo_q;  // operand signs differ
  logic               neg_rem_q;  // dividend was negative
`endif

  assign accept   = (state_q == S_IDLE) && start;
  assign dvs_zero = (divisor == '0);

  // Operand magnitudes captured at accept
  always_comb begin
    dvd_mag = dividend;
    dvs_mag = divisor;
`ifdef DIV_SIGNED_EN
    if (is_signed && dividend[WIDTH-1]) dvd_mag = -dividend;
    if (is_signed && divisor[WIDTH-1])  dvs_mag = -divisor;
`endif
  end

  // Shared subtractor. The remainder is always < divisor, so the shifted
  // value fits WIDTH+1 bits and the MSB of the difference is a clean sign.
  assign sub_a   = {rem_q, dvd_q[WIDTH-1]};
  assign sub_b   = {1'b0, dvs_q};
  assign sub_res = sub_a - sub_b;
  assign sgn     = sub_res[WIDTH];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = dvs_zero ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (cnt_q == '0) begin
`ifdef DIV_SIGNED_EN
          state_d = fix_q ? S_FIX : S_DONE;
`else
          state_d = S_DONE;
`endif
        end
      end
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy      = (state_q != S_IDLE);
    dbg_state = state_q;
  end

  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dz_q;

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dz_q        <= 1'b0;
      done_q      <= 1'b0;
`ifdef DIV_SIGNED_EN
      fix_q       <= 1'b0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
`endif
    end else begin
      // done follows the DONE state by one edge, so it rises together with
      // the freshly loaded result registers.
      done_q <= (state_q == S_DONE);
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (dvs_zero) begin
              quo_q <= '1;
              rem_q <= dividend;
              dz_q  <= 1'b1;
`ifdef DIV_SIGNED_EN
              fix_q <= 1'b0;
`endif
            end else begin
              dvd_q <= dvd_mag;
              dvs_q <= dvs_mag;
              rem_q <= '0;
              quo_q <= '0;
              cnt_q <= CNT_W'(WIDTH - 1);
              dz_q  <= 1'b0;
`ifdef DIV_SIGNED_EN
              fix_q     <= is_signed;
              neg_quo_q <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
              neg_rem_q <= is_signed && dividend[WIDTH-1];
`endif
            end
          end
        end
        S_RUN: begin
          dvd_q <= dvd_q << 1;
          quo_q <= {quo_q[WIDTH-2:0], ~sgn};
          rem_q <= sgn ? sub_a[WIDTH-1:0] : sub_res[WIDTH-1:0];
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        end
`ifdef DIV_SIGNED_EN
        S_FIX: begin
          if (neg_quo_q) quo_q <= -quo_q;
          if (neg_rem_q) rem_q <= -rem_q;
        end
`endif
        S_DONE: begin
          quotient_q  <= quo_q;
          remainder_q <= rem_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_divider_ctrl.sv
module tb_sub_divider_ctrl;

  localparam int W = 8;
  localparam int PERIOD = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #(PERIOD/2) clk = ~clk;

  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;
  logic [1:0]   dbg_state;
`ifdef DIV_SIGNED_EN
  logic         is_signed = 1'b0;
`endif

  sub_divider_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .dividend(dividend), .divisor(divisor),
`ifdef DIV_SIGNED_EN
    .is_signed(is_signed),
`endif
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  // expected entry: {div_by_zero, quotient, remainder}
  logic [2*W:0] exp_q[$];
  int           lat_q[$];
  longint       acc_q[$];
  int checks = 0;
  int failures = 0;
  logic prev_done = 1'b0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: plain arithmetic on the operands
  task automatic push_expect(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgnd);
    logic [W-1:0] q, r;
    int lat;
    if (b == 0) begin
      q = '1; r = a; lat = 1;
    end else if (sgnd) begin
      int sa, sb;
      sa = int'($signed(a)); sb = int'($signed(b));
      q = W'(sa / sb); r = W'(sa % sb); lat = W + 2;
    end else begin
      q = a / b; r = a % b; lat = W + 1;
    end
    exp_q.push_back({(b == 0), q, r});
    lat_q.push_back(lat);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst) begin
      prev_done = 1'b0;
    end else begin
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
        end else begin
          logic [2*W:0] e;
          int l;
          longint t;
          e = exp_q.pop_front();
          l = lat_q.pop_front();
          t = acc_q.size() > 0 ? acc_q.pop_front() : 0;
          check("quotient", quotient, e[2*W-1:W]);
          check("remainder", remainder, e[W-1:0]);
          check("div_by_zero", div_by_zero, e[2*W]);
          check("latency", ($time - t - PERIOD/2) / PERIOD, l);
        end
        check("done_single_cycle", prev_done, 0);
      end
      prev_done = done;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgnd);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
`ifdef DIV_SIGNED_EN
    is_signed = sgnd;
`endif
    push_expect(a, b, sgnd);
    @(posedge clk);
    acc_q.push_back($time);
    #1 start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 4*W + 20) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete(); lat_q.delete(); acc_q.delete();
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgnd);
    issue(a, b, sgnd);
    drain();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] ra, rb;
    longint t0;
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_quotient", quotient, 0);
    check("reset_remainder", remainder, 0);
    check("reset_dbz", div_by_zero, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    run_op(8'd100, 8'd7, 1'b0);
    repeat (3) @(negedge clk);
    check("hold_quotient", quotient, 14);
    check("hold_remainder", remainder, 2);
    run_op(8'd255, 8'd1, 1'b0);
    run_op(8'd5, 8'd9, 1'b0);
    run_op(8'd200, 8'd200, 1'b0);
    run_op(8'd42, 8'd0, 1'b0);
    check("dbz_held", div_by_zero, 1);
    run_op(8'd0, 8'd5, 1'b0);
    run_op(8'd255, 8'd255, 1'b0);
    run_op(8'd1, 8'd255, 1'b0);

    // Start while busy is dropped: only one done expected
    issue(8'd100, 8'd7, 1'b0);
    repeat (3) @(negedge clk);
    check("busy_in_run", busy, 1);
    start = 1'b1; dividend = 8'd9; divisor = 8'd3;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (W + 4) @(negedge clk);

    // start held high: back-to-back accepts every W+2 cycles
    @(negedge clk);
    start = 1'b1; dividend = 8'd77; divisor = 8'd6;
`ifdef DIV_SIGNED_EN
    is_signed = 1'b0;
`endif
    push_expect(8'd77, 8'd6, 1'b0);
    push_expect(8'd77, 8'd6, 1'b0);
    @(posedge clk);
    t0 = $time;
    acc_q.push_back(t0);
    acc_q.push_back(t0 + (W + 2) * PERIOD);
    repeat (W + 2) @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    drain();

    // Random unsigned operations
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom_range(0, 255));
      case ($urandom_range(0, 3))
        0:       rb = W'($urandom_range(0, 3));
        1:       rb = W'($urandom_range(1, 15));
        default: rb = W'($urandom_range(0, 255));
      endcase
      run_op(ra, rb, 1'b0);
    end

`ifdef DIV_SIGNED_EN
    run_op(8'h9C, 8'd7, 1'b1);
    run_op(8'h80, 8'hFF, 1'b1);
    run_op(8'h9C, 8'h00, 1'b1);
    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      run_op(ra, rb, 1'b1);
    end
`endif

    // Reset mid-RUN: immediate clear, no done afterwards
    issue(8'd200, 8'd3, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    exp_q.delete(); lat_q.delete(); acc_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (W + 6) @(negedge clk);
    check("post_rst_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
